// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file constants and address type
package mips_pkg;
   localparam int REG_ZERO = 0;
   localparam int REG_V0   = 2;

   typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write scoreboard with RAW busy/stall detection
module regfile_scoreboard
   import mips_pkg::*;
#(
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int ADDR_W = $clog2(NREGS),
   parameter int CNT_W  = $clog2(NREGS+1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   input  logic [NRD-1:0]        rd_req,
   input  logic                  issue_en,
   input  logic [ADDR_W-1:0]     issue_addr,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   output logic [NRD-1:0]        rd_busy,
   output logic                  stall_o,
   output logic [CNT_W-1:0]      pend_count,
   output logic                  err_wb
);

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pend_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             wr_live;
   logic             issue_live;
   logic             wb_orphan;

   assign wr_live    = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
   assign issue_live = issue_en && (issue_addr != ADDR_W'(REG_ZERO));
   assign wb_orphan  = wr_live && !pending[wr_addr] && !(issue_en && issue_addr == wr_addr);

   // Issue is applied after the clear so a same-cycle new producer keeps the register pending.
   always_comb begin
      pend_nxt = pending;
      if (wr_live)
         pend_nxt[wr_addr] = 1'b0;
      if (issue_live)
         pend_nxt[issue_addr] = 1'b1;
      cnt_nxt = '0;
      for (int i = 0; i < NREGS; i++)
         cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= '0;
         pend_count <= '0;
         err_wb     <= 1'b0;
      end else begin
         pending    <= pend_nxt;
         pend_count <= cnt_nxt;
         err_wb     <= err_wb | wb_orphan;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_busy
      logic [ADDR_W-1:0] a;
      assign a          = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_busy[k] = (a != ADDR_W'(REG_ZERO)) && pending[a] && !(wr_en && wr_addr == a);
   end

   assign stall_o = |(rd_busy & rd_req);

endmodule

// File: rtl/mips_regfile_sb.sv
// rtl/mips_regfile_sb.sv - multi-port MIPS register file with write bypass and scoreboard
module mips_regfile_sb
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int ADDR_W = $clog2(NREGS),
   parameter int CNT_W  = $clog2(NREGS+1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   output logic                  stall_o,
   input  logic [NRD-1:0]        rd_req,
   input  logic                  issue_en,
   input  logic [ADDR_W-1:0]     issue_addr,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [CNT_W-1:0]      pend_count,
   output logic                  err_wb,
   output logic [DATA_W-1:0]     register_v0
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_en && wr_addr != ADDR_W'(REG_ZERO)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // r0 reads as zero regardless of array contents or a same-cycle writeback to it.
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W] =
         (a == ADDR_W'(REG_ZERO))   ? '0 :
         (wr_en && wr_addr == a)    ? wr_data :
                                      regs[a];
   end

   assign register_v0 = regs[REG_V0];

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .rd_addr   (rd_addr),
      .rd_req    (rd_req),
      .issue_en  (issue_en),
      .issue_addr(issue_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rd_busy   (rd_busy),
      .stall_o   (stall_o),
      .pend_count(pend_count),
      .err_wb    (err_wb)
   );

endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb/tb_mips_regfile_sb.sv - directed self-checking bench for mips_regfile_sb
module tb_mips_regfile_sb;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        stall_o;
   logic [1:0]  rd_req;
   logic        issue_en;
   reg_addr_t   issue_addr;
   logic        wr_en;
   reg_addr_t   wr_addr;
   logic [31:0] wr_data;
   logic [5:0]  pend_count;
   logic        err_wb;
   logic [31:0] register_v0;

   int vectors = 0;
   int miscompares = 0;

   mips_regfile_sb dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .stall_o    (stall_o),
      .rd_req     (rd_req),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .pend_count (pend_count),
      .err_wb     (err_wb),
      .register_v0(register_v0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_en = 1'b0; issue_addr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
      rd_addr = {a1, a0};
   endtask

   initial begin
      reset = 1'b1; rd_req = 2'b00;
      idle(); set_rd(5'd0, 5'd0);
      tick();
      reset = 1'b0;
      #1;
      check("rst_pend", 32'(pend_count), 32'd0);
      check("rst_err", 32'(err_wb), 32'd0);
      check("rst_v0", register_v0, 32'd0);

      // reset clears a written register
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD; set_rd(5'd5, 5'd0);
      #1 check("r5_bypass", rd_data[31:0], 32'hDEAD);
      tick();
      idle(); reset = 1'b1;
      #1 check("r5_stored", rd_data[31:0], 32'hDEAD);
      check("r5_orphan_err", 32'(err_wb), 32'd1);
      tick();
      reset = 1'b0;
      #1 check("r5_after_rst", rd_data[31:0], 32'd0);
      check("err_after_rst", 32'(err_wb), 32'd0);
      check("pend_after_rst", 32'(pend_count), 32'd0);

      // issue r7, then bypass its writeback
      issue_en = 1'b1; issue_addr = 5'd7; set_rd(5'd7, 5'd0);
      tick();
      idle();
      #1 check("r7_pend", 32'(pend_count), 32'd1);
      check("r7_busy", 32'(rd_busy), 32'd1);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
      #1 check("r7_bypass", rd_data[31:0], 32'h1234);
      check("r7_busy_wb", 32'(rd_busy), 32'd0);
      tick();
      idle();
      #1 check("r7_reg", rd_data[31:0], 32'h1234);
      check("r7_pend_clr", 32'(pend_count), 32'd0);
      check("r7_err", 32'(err_wb), 32'd0);

      // r0 writes and issues are ignored
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
      issue_en = 1'b1; issue_addr = 5'd0; set_rd(5'd0, 5'd0); rd_req = 2'b11;
      #1 check("r0_data", rd_data[31:0], 32'd0);
      check("r0_busy", 32'(rd_busy), 32'd0);
      check("r0_stall", 32'(stall_o), 32'd0);
      tick();
      idle();
      #1 check("r0_pend", 32'(pend_count), 32'd0);
      check("r0_err", 32'(err_wb), 32'd0);
      check("r0_data_after", rd_data[63:32], 32'd0);

      // RAW on r3 with stall gated by rd_req
      issue_en = 1'b1; issue_addr = 5'd3; set_rd(5'd3, 5'd3); rd_req = 2'b01;
      tick();
      idle();
      #1 check("r3_busy", 32'(rd_busy), 32'd3);
      check("r3_stall", 32'(stall_o), 32'd1);
      check("r3_pend", 32'(pend_count), 32'd1);
      rd_req = 2'b00;
      #1 check("r3_stall_noreq", 32'(stall_o), 32'd0);
      rd_req = 2'b01; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAB;
      #1 check("r3_busy_wb", 32'(rd_busy), 32'd0);
      check("r3_stall_wb", 32'(stall_o), 32'd0);
      check("r3_bypass", rd_data[63:32], 32'hAB);
      tick();
      idle(); rd_req = 2'b00;
      #1 check("r3_pend_clr", 32'(pend_count), 32'd0);
      check("r3_err", 32'(err_wb), 32'd0);

      // same-cycle issue and writeback on a pending register keeps it pending
      issue_en = 1'b1; issue_addr = 5'd4; set_rd(5'd4, 5'd0);
      tick();
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
      tick();
      idle();
      #1 check("r4_pend", 32'(pend_count), 32'd1);
      check("r4_busy", 32'(rd_busy), 32'd1);
      check("r4_data", rd_data[31:0], 32'h55);
      check("r4_err", 32'(err_wb), 32'd0);
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h66;
      tick();
      idle();
      #1 check("r4_pend_clr", 32'(pend_count), 32'd0);

      // debug tap shows the registered r2 value only
      issue_en = 1'b1; issue_addr = 5'd2;
      tick();
      idle(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hCAFE;
      #1 check("v0_no_bypass", register_v0, 32'd0);
      tick();
      idle();
      #1 check("v0_reg", register_v0, 32'hCAFE);

      // orphan writeback sets sticky error but still writes
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; set_rd(5'd0, 5'd9);
      tick();
      idle();
      #1 check("r9_err", 32'(err_wb), 32'd1);
      check("r9_data", rd_data[63:32], 32'h99);
      tick();
      #1 check("r9_err_sticky", 32'(err_wb), 32'd1);
      check("r9_pend", 32'(pend_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
